data_cache_dm: RTL and testbench

DATA_CACHE_DM -- requirements
Module: data_cache_dm

---
 rtl/data_cache_pkg.sv | 16 +
 rtl/cache_line_array.sv | 46 ++++
 rtl/data_cache_dm.sv | 145 ++++++++++++++
 tb/tb_data_cache_dm.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// controller state encoding and default parameter values.
package data_cache_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_LINES  = 16;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MISS_RD = 2'd1,
      WR_THRU = 2'd2
   } state_t;

endpackage

// File: rtl/cache_line_array.sv
// Tag/valid/data storage for one-word direct-mapped lines: combinational read,
// one synchronous write port, single-cycle invalidate of all valid bits.
module cache_line_array #(
   parameter int TAG_W  = 28,
   parameter int DATA_W = 32,
   parameter int LINES  = 16,
   parameter int IDX_W  = $clog2(LINES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [DATA_W-1:0] rd_data,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [DATA_W-1:0] wr_data
);

   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tags  [LINES];
   logic [DATA_W-1:0] words [LINES];

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tags[rd_idx];
   assign rd_data  = words[rd_idx];

   // Invalidate wins over a fill; the controller never issues both together.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid <= '0;
      end else if (we) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         tags[wr_idx]  <= wr_tag;
         words[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/data_cache_dm.sv
// Direct-mapped, one-word-line, write-through/no-write-allocate data cache with
// a blocking three-state controller and saturating read hit/miss counters.
module data_cache_dm
   import data_cache_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LINES  = DEF_LINES,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_busy,
   input  logic              flush,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX_W;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_t            state;
   logic              wr_hit;
   logic              line_valid;
   logic [TAG_W-1:0]  line_tag;
   logic [DATA_W-1:0] line_data;
   logic              lookup_hit;
   logic              accept;
   logic              flush_now;
   logic              arr_we;
   logic [DATA_W-1:0] arr_data;

   assign accept    = (state == IDLE) && cpu_req;
   assign flush_now = (state == IDLE) && flush;
   assign cpu_busy  = (state != IDLE);

   // A flush arriving with the request makes the lookup see an empty array.
   assign lookup_hit = line_valid && !flush
                       && (line_tag == cpu_addr[ADDR_W-1:IDX_W]);

   assign arr_we   = !rst && mem_ack
                     && ((state == MISS_RD) || ((state == WR_THRU) && wr_hit));
   assign arr_data = (state == MISS_RD) ? mem_rdata : mem_wdata;

   cache_line_array #(
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W),
      .LINES  (LINES),
      .IDX_W  (IDX_W)
   ) u_lines (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush_now),
      .rd_idx   (cpu_addr[IDX_W-1:0]),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .we       (arr_we),
      .wr_idx   (mem_addr[IDX_W-1:0]),
      .wr_tag   (mem_addr[ADDR_W-1:IDX_W]),
      .wr_data  (arr_data)
   );

   // Request payload doubles as the backing-memory payload; held until ack.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_addr  <= cpu_addr;
         mem_wdata <= cpu_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_hit    <= 1'b0;
         cpu_ready <= 1'b0;
         cpu_rdata <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
      end else begin
         cpu_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  if (cpu_we) begin
                     state   <= WR_THRU;
                     mem_req <= 1'b1;
                     mem_we  <= 1'b1;
                     wr_hit  <= lookup_hit;
                  end else if (lookup_hit) begin
                     cpu_ready <= 1'b1;
                     cpu_rdata <= line_data;
                     hit_cnt   <= sat_inc(hit_cnt);
                  end else begin
                     state    <= MISS_RD;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     miss_cnt <= sat_inc(miss_cnt);
                  end
               end
            end
            MISS_RD: begin
               if (mem_ack) begin
                  state     <= IDLE;
                  mem_req   <= 1'b0;
                  cpu_ready <= 1'b1;
                  cpu_rdata <= mem_rdata;
               end
            end
            WR_THRU: begin
               if (mem_ack) begin
                  state     <= IDLE;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  cpu_ready <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_cache_dm.sv
// Directed bench for data_cache_dm (LINES=16, CNT_W=2) with hand-derived
// expectations for hits, misses, conflicts, writes, flush, reset and saturation.
module tb_data_cache_dm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        cpu_busy;
   logic        flush = 1'b0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic [1:0]  hit_cnt;
   logic [1:0]  miss_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_cache_dm #(
      .ADDR_W (32),
      .DATA_W (32),
      .LINES  (16),
      .CNT_W  (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .cpu_busy  (cpu_busy),
      .flush     (flush),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read that must miss; memory acks after lat cycles of mem_req.
   task automatic rd_miss(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input int lat, input logic fl_busy);
      int req_cycles;
      req_cycles = 0;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = a;
      tick();
      cpu_req = 1'b0;
      flush   = fl_busy;
      chk({tag, "_busy"}, 32'(cpu_busy), 32'd1);
      chk({tag, "_memwe"}, 32'(mem_we), 32'd0);
      chk({tag, "_memaddr"}, mem_addr, a);
      chk({tag, "_noready"}, 32'(cpu_ready), 32'd0);
      for (int i = 0; i < lat - 1; i++) begin
         if (mem_req) req_cycles++;
         tick();
      end
      if (mem_req) req_cycles++;
      mem_ack   = 1'b1;
      mem_rdata = d;
      tick();
      mem_ack = 1'b0;
      flush   = 1'b0;
      chk({tag, "_reqcycles"}, 32'(req_cycles), 32'(lat));
      chk({tag, "_reqdrop"}, 32'(mem_req), 32'd0);
      chk({tag, "_ready"}, 32'(cpu_ready), 32'd1);
      chk({tag, "_rdata"}, cpu_rdata, d);
   endtask

   task automatic rd_hit(input string tag, input logic [31:0] a, input logic [31:0] d);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = a;
      tick();
      cpu_req = 1'b0;
      chk({tag, "_ready"}, 32'(cpu_ready), 32'd1);
      chk({tag, "_rdata"}, cpu_rdata, d);
      chk({tag, "_nomemreq"}, 32'(mem_req), 32'd0);
   endtask

   task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d);
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = a;
      cpu_wdata = d;
      tick();
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
      chk({tag, "_memreq"}, 32'(mem_req), 32'd1);
      chk({tag, "_memwe"}, 32'(mem_we), 32'd1);
      chk({tag, "_memaddr"}, mem_addr, a);
      chk({tag, "_memwdata"}, mem_wdata, d);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk({tag, "_ready"}, 32'(cpu_ready), 32'd1);
      chk({tag, "_reqdrop"}, 32'(mem_req), 32'd0);
      chk({tag, "_wedrop"}, 32'(mem_we), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_ready", 32'(cpu_ready), 32'd0);
      chk("rst_memreq", 32'(mem_req), 32'd0);
      chk("rst_memwe", 32'(mem_we), 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      chk("rst_busy", 32'(cpu_busy), 32'd0);
      chk("rst_hit", 32'(hit_cnt), 32'd0);
      chk("rst_miss", 32'(miss_cnt), 32'd0);

      // Cold miss then hit on 0x23
      rd_miss("miss23", 32'h23, 32'hDEADBEEF, 3, 1'b0);
      chk("miss23_cnt", 32'(miss_cnt), 32'd1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("idle_ack_ready", 32'(cpu_ready), 32'd0);
      chk("idle_ack_busy", 32'(cpu_busy), 32'd0);
      rd_hit("hit23", 32'h23, 32'hDEADBEEF);
      chk("hit23_cnt", 32'(hit_cnt), 32'd1);
      tick();
      chk("hold_ready", 32'(cpu_ready), 32'd0);
      chk("hold_rdata", cpu_rdata, 32'hDEADBEEF);

      // Conflict misses on index 3; miss counter saturates at 3
      rd_miss("miss03a", 32'h03, 32'h11110003, 1, 1'b0);
      chk("miss03a_cnt", 32'(miss_cnt), 32'd2);
      rd_miss("miss13", 32'h13, 32'h22220013, 2, 1'b0);
      chk("miss13_cnt", 32'(miss_cnt), 32'd3);
      rd_miss("miss03b", 32'h03, 32'h33330003, 1, 1'b0);
      chk("miss_sat", 32'(miss_cnt), 32'd3);

      // Write hit updates the line; write miss does not allocate
      wr("wr03", 32'h03, 32'h55);
      chk("wr03_hitcnt", 32'(hit_cnt), 32'd1);
      rd_hit("hit03w", 32'h03, 32'h55);
      chk("hit03w_cnt", 32'(hit_cnt), 32'd2);
      wr("wr07", 32'h07, 32'h77);
      rd_miss("miss07", 32'h07, 32'hAAAA0007, 1, 1'b0);

      // Back-to-back hits accepted on the ready cycle
      cpu_req  = 1'b1;
      cpu_addr = 32'h03;
      tick();
      chk("b2b1_ready", 32'(cpu_ready), 32'd1);
      chk("b2b1_rdata", cpu_rdata, 32'h55);
      cpu_addr = 32'h07;
      tick();
      cpu_req = 1'b0;
      chk("b2b2_ready", 32'(cpu_ready), 32'd1);
      chk("b2b2_rdata", cpu_rdata, 32'hAAAA0007);
      chk("hit_sat", 32'(hit_cnt), 32'd3);

      // Flush with a read of cached 0x03; flush during busy is ignored
      flush = 1'b1;
      rd_miss("flush03", 32'h03, 32'h44440003, 1, 1'b0);
      rd_miss("flush07", 32'h07, 32'hBBBB0007, 2, 1'b1);
      rd_hit("post07", 32'h07, 32'hBBBB0007);
      rd_hit("post03", 32'h03, 32'h44440003);

      // Reset in the middle of a read miss
      cpu_req  = 1'b1;
      cpu_addr = 32'h09;
      tick();
      cpu_req = 1'b0;
      chk("rstmid_memreq", 32'(mem_req), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid_reqdrop", 32'(mem_req), 32'd0);
      chk("rstmid_busy", 32'(cpu_busy), 32'd0);
      chk("rstmid_hit", 32'(hit_cnt), 32'd0);
      chk("rstmid_miss", 32'(miss_cnt), 32'd0);
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF0009;
      tick();
      mem_ack = 1'b0;
      chk("late_ack_ready", 32'(cpu_ready), 32'd0);
      chk("late_ack_memreq", 32'(mem_req), 32'd0);
      tick();
      chk("late_ack_ready2", 32'(cpu_ready), 32'd0);
      rd_miss("postrst03", 32'h03, 32'h66660003, 1, 1'b0);

      // Hit counter saturation: five hits on 0x05
      rd_miss("miss05", 32'h05, 32'h12345678, 1, 1'b0);
      chk("miss05_cnt", 32'(miss_cnt), 32'd2);
      cpu_req  = 1'b1;
      cpu_addr = 32'h05;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("sat_ready", 32'(cpu_ready), 32'd1);
         chk("sat_rdata", cpu_rdata, 32'h12345678);
      end
      cpu_req = 1'b0;
      tick();
      chk("sat_hit_cnt", 32'(hit_cnt), 32'd3);
      chk("sat_miss_cnt", 32'(miss_cnt), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
